// File: rtl/encode_mul_pipe_sat.sv
// encode_mul_pipe_sat
// Pipelined signed multiplier: full-precision product, arithmetic right shift
// by SHIFT, saturation to dout_WIDTH. A valid bit travels alongside the data.
// Every register advances only on ce; reset clears everything regardless of ce.
// Optional build macro ENCODE_MUL_ROUND_EN: add 2^(SHIFT-1) before shifting
// (round half up). When undefined the shift truncates and no adder exists.
module encode_mul_pipe_sat #(
  parameter int din0_WIDTH = 40,
  parameter int din1_WIDTH = 25,
  parameter int dout_WIDTH = 32,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         din_valid,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         dout_valid,
  output logic                         dout_sat
);

  // Full product width, plus one guard bit so the rounding add cannot wrap.
  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int WW = PW + 1;

  // Saturation thresholds expressed at the wide width for a signed compare.
  localparam logic signed [WW-1:0] SAT_MAX =
    {{(WW - dout_WIDTH + 1){1'b0}}, {(dout_WIDTH - 1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN =
    {{(WW - dout_WIDTH + 1){1'b1}}, {(dout_WIDTH - 1){1'b0}}};
  localparam logic signed [dout_WIDTH-1:0] OUT_MAX = {1'b0, {(dout_WIDTH - 1){1'b1}}};
  localparam logic signed [dout_WIDTH-1:0] OUT_MIN = {1'b1, {(dout_WIDTH - 1){1'b0}}};

`ifdef ENCODE_MUL_ROUND_EN
  // Half an output LSB; zero when there is no shift so nothing is added.
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [WW-1:0] RND_ONE = {{(WW - 1){1'b0}}, 1'b1};
  localparam logic signed [WW-1:0] RND_K = (SHIFT > 0) ? (RND_ONE << RND_POS) : '0;
`endif

  // Sign-extend both operands to the product width so the multiply is exact.
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;

  assign a_ext = {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0};
  assign b_ext = {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1};
  assign prod  = a_ext * b_ext;

  logic signed [PW-1:0]  p_last;
  logic [NUM_STAGE-1:0]  valid_reg;

  generate
    if (NUM_STAGE == 1) begin : g_direct
      // Single stage: the product feeds the scale/saturate logic directly.
      assign p_last = prod;

      // Valid tracks the one data register.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg <= '0;
        end else if (ce) begin
          valid_reg <= din_valid;
        end
      end
    end else begin : g_pipe
      logic signed [PW-1:0] p_reg [NUM_STAGE-1];

      // Product register followed by plain delay stages.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < NUM_STAGE - 1; i++) begin
            p_reg[i] <= '0;
          end
        end else if (ce) begin
          p_reg[0] <= prod;
          for (int i = 1; i < NUM_STAGE - 1; i++) begin
            p_reg[i] <= p_reg[i-1];
          end
        end
      end

      // Valid shift register, same length as the data path.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg <= '0;
        end else if (ce) begin
          valid_reg <= {valid_reg[NUM_STAGE-2:0], din_valid};
        end
      end

      assign p_last = p_reg[NUM_STAGE-2];
    end
  endgenerate

  logic signed [WW-1:0]         wide;
  logic signed [WW-1:0]         scaled;
  logic signed [dout_WIDTH-1:0] dout_next;
  logic                         sat_next;
  logic signed [dout_WIDTH-1:0] dout_reg;
  logic                         sat_reg;

  // Optional round, arithmetic shift, then clip into the output range.
  always_comb begin
    wide = {p_last[PW-1], p_last};
`ifdef ENCODE_MUL_ROUND_EN
    wide = wide + RND_K;
`endif
    scaled    = wide >>> SHIFT;
    dout_next = scaled[dout_WIDTH-1:0];
    sat_next  = 1'b0;
    if (scaled > SAT_MAX) begin
      dout_next = OUT_MAX;
      sat_next  = 1'b1;
    end else if (scaled < SAT_MIN) begin
      dout_next = OUT_MIN;
      sat_next  = 1'b1;
    end
  end

  // Final register holding the result and its saturation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_reg <= '0;
      sat_reg  <= 1'b0;
    end else if (ce) begin
      dout_reg <= dout_next;
      sat_reg  <= sat_next;
    end
  end

  assign dout       = dout_reg;
  assign dout_sat   = sat_reg;
  assign dout_valid = valid_reg[NUM_STAGE-1];

endmodule
